// File: rtl/ram_pkg.sv
// Shared types and helpers for the simple dual-port byte-enable RAM.
package ram_pkg;

    typedef enum logic {
        RAM_CLEAR,
        RAM_RUN
    } ram_state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // One byte lane of a byte-enable merge; the write path and the
    // read-during-write forwarding path both build their words from this.
    function automatic logic [7:0] be_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       be
    );
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/ram_init_clear.sv
// Post-reset zeroing sweep: walks every address once, then reports ready.
//
// state     | meaning
// ----------+-------------------------------------------------------
// RAM_CLEAR | writing zero to clear_addr this cycle, counter advancing
// RAM_RUN   | sweep finished (or disabled); user traffic accepted
module ram_init_clear
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  clear_we,
    output logic [ADDR_WIDTH-1:0] clear_addr,
    output logic                  ready
);

    ram_state_e            state;
    logic [ADDR_WIDTH-1:0] cnt;

    assign clear_addr = cnt;

    // Sweep FSM; clear_we and ready are registered so the array sees a clean strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= (CLEAR_ON_RESET != 0) ? RAM_CLEAR : RAM_RUN;
            cnt      <= '0;
            clear_we <= (CLEAR_ON_RESET != 0);
            ready    <= 1'b0;
        end else begin
            case (state)
                RAM_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state    <= RAM_RUN;
                        clear_we <= 1'b0;
                        ready    <= 1'b1;
                    end
                end
                RAM_RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= RAM_RUN;
                end
            endcase
        end
    end

endmodule

// File: rtl/ram_sdp_be.sv
// Simple dual-port RAM: one byte-enabled write port, one pipelined read
// port, selectable same-address read-during-write policy, optional clear.
module ram_sdp_be
    import ram_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int RAM_DATA_WIDTH = 32,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_wr_en,
    input  logic [RAM_ADDR_WIDTH-1:0]   i_wr_addr,
    input  logic [RAM_DATA_WIDTH-1:0]   i_wr_data,
    input  logic [RAM_DATA_WIDTH/8-1:0] i_wr_be,
    input  logic                        i_rd_en,
    input  logic [RAM_ADDR_WIDTH-1:0]   i_rd_addr,
    output logic [RAM_DATA_WIDTH-1:0]   o_rd_data,
    output logic                        o_rd_valid,
    output logic                        o_ready
);

    localparam int RAM_DEPTH = 2 ** RAM_ADDR_WIDTH;
    localparam int BE_WIDTH  = RAM_DATA_WIDTH / 8;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("ram_sdp_be: READ_LATENCY must be 1 or 2");
    end
    if (RAM_DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("ram_sdp_be: RAM_DATA_WIDTH must be a multiple of 8");
    end
    if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_bad_rdw
        $error("ram_sdp_be: RDW_MODE must be 0 or 1");
    end

    logic                      clear_we;
    logic [RAM_ADDR_WIDTH-1:0] clear_addr;
    logic                      ready;
    logic                      wr_go;
    logic                      rd_go;
    logic                      fwd_hit;
    logic [RAM_DATA_WIDTH-1:0] wr_merged;
    logic [RAM_DATA_WIDTH-1:0] rd_word;
    logic                      s1_valid;
    logic [RAM_DATA_WIDTH-1:0] s1_data;
    logic [RAM_DATA_WIDTH-1:0] mem [RAM_DEPTH];

    ram_init_clear #(
        .ADDR_WIDTH     (RAM_ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_init_clear (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_we   (clear_we),
        .clear_addr (clear_addr),
        .ready      (ready)
    );

    assign o_ready = ready;
    assign wr_go   = ready & i_wr_en;
    assign rd_go   = ready & i_rd_en;

    // Merged word at the write address; on a same-address hit this is also
    // exactly the word the NEW policy must return.
    for (genvar k = 0; k < BE_WIDTH; k++) begin : g_lane
        assign wr_merged[8*k +: 8] = be_merge(mem[i_wr_addr][8*k +: 8],
                                              i_wr_data[8*k +: 8], i_wr_be[k]);
    end

    assign fwd_hit = (RDW_MODE == RDW_NEW) && wr_go && (i_wr_addr == i_rd_addr);
    assign rd_word = fwd_hit ? wr_merged : mem[i_rd_addr];

    // Array write port: the clear sweep owns the port until ready rises.
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[clear_addr] <= '0;
        end else if (wr_go) begin
            mem[i_wr_addr] <= wr_merged;
        end
    end

    // First read stage; data holds between accepted reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_go;
            if (rd_go) begin
                s1_data <= rd_word;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                      s2_valid;
        logic [RAM_DATA_WIDTH-1:0] s2_data;

        // Extra output register stage, loaded only when stage one holds a read.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign o_rd_valid = s2_valid;
        assign o_rd_data  = s2_data;
    end else begin : g_lat1
        assign o_rd_valid = s1_valid;
        assign o_rd_data  = s1_data;
    end

endmodule

// File: tb/tb_ram_sdp_be.sv
// Bench for ram_sdp_be: two instances share stimulus (latency 1 / OLD policy
// and latency 2 / NEW policy) and are compared against a word-level model.
module tb_ram_sdp_be;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_be;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data_a, rd_data_b;
    logic          rd_valid_a, rd_valid_b;
    logic          ready_a, ready_b;

    ram_sdp_be #(.RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW), .READ_LATENCY(1),
                 .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_wr_be(wr_be), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data_a), .o_rd_valid(rd_valid_a), .o_ready(ready_a));

    ram_sdp_be #(.RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW), .READ_LATENCY(2),
                 .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_wr_be(wr_be), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data_b), .o_rd_valid(rd_valid_b), .o_ready(ready_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_exp_t;

    logic [31:0] mem_m [DEPTH];
    int          sweep_cnt;
    bit          m_ready;
    int          cyc;
    rd_exp_t     q_a[$];
    rd_exp_t     q_b[$];
    logic [31:0] last_a, last_b;
    int          n_pass, n_chk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    endtask

    function automatic logic [31:0] merge_model(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0] be);
        logic [31:0] mask;
        mask = 32'h0;
        for (int k = 0; k < 4; k++) if (be[k]) mask = mask | (32'hFF << (8 * k));
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    // What one rising edge does, from the model's point of view.
    task automatic model_edge();
        logic [31:0] old_w, new_w;
        if (!m_ready) begin
            mem_m[sweep_cnt] = 32'h0;
            sweep_cnt++;
            if (sweep_cnt == DEPTH) m_ready = 1'b1;
        end else begin
            if (rd_en) begin
                old_w = mem_m[rd_addr];
                new_w = old_w;
                if (wr_en && wr_addr == rd_addr) new_w = merge_model(old_w, wr_data, wr_be);
                q_a.push_back('{due: cyc, data: old_w});
                q_b.push_back('{due: cyc + 1, data: new_w});
            end
            if (wr_en) mem_m[wr_addr] = merge_model(mem_m[wr_addr], wr_data, wr_be);
        end
    endtask

    task automatic check_outputs();
        bit ev_a, ev_b;
        chk("ready_a", 32'(ready_a), 32'(m_ready));
        chk("ready_b", 32'(ready_b), 32'(m_ready));
        ev_a = (q_a.size() > 0) && (q_a[0].due == cyc);
        if (ev_a) begin last_a = q_a[0].data; void'(q_a.pop_front()); end
        ev_b = (q_b.size() > 0) && (q_b[0].due == cyc);
        if (ev_b) begin last_b = q_b[0].data; void'(q_b.pop_front()); end
        chk("valid_a", 32'(rd_valid_a), 32'(ev_a));
        chk("data_a", rd_data_a, last_a);
        chk("valid_b", 32'(rd_valid_b), 32'(ev_b));
        chk("data_b", rd_data_b, last_b);
    endtask

    // Advance one clock: model at the rising edge, compare at the falling edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst_n) model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic apply_reset(input int n);
        rst_n     = 1'b0;
        m_ready   = 1'b0;
        sweep_cnt = 0;
        q_a.delete();
        q_b.delete();
        last_a = 32'h0;
        last_b = 32'h0;
        #1;
        chk("rst_ready", 32'(ready_a), 32'h0);
        chk("rst_valid", 32'(rd_valid_b), 32'h0);
        chk("rst_data", rd_data_b, 32'h0);
        for (int i = 0; i < n; i++) tick();
        rst_n = 1'b1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        int n;
        n_pass = 0; n_chk = 0; cyc = 0;
        wr_en = 0; wr_addr = '0; wr_data = '0; wr_be = '0; rd_en = 0; rd_addr = '0;
        rst_n = 1'b0;
        @(negedge clk);
        apply_reset(2);

        // Traffic during the sweep must be ignored; abort the sweep at address 7.
        wr_en = 1'b1; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF; wr_addr = 4'd9;
        rd_en = 1'b1; rd_addr = 4'd2;
        for (int i = 0; i < 7; i++) tick();
        apply_reset(2);

        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ready_a) begin n = i; break; end
        end
        chk("sweep_len", 32'(n), 32'd16);
        idle();

        // Every word reads back zero after the sweep.
        for (int i = 0; i < DEPTH; i++) begin
            rd_en = 1'b1; rd_addr = AW'(i);
            tick();
            chk("clear_rd", rd_data_a, 32'h0);
        end
        idle(); tick(); tick();

        // Byte-enable merge.
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hAABBCCDD; wr_be = 4'hF; tick();
        wr_data = 32'h11223344; wr_be = 4'b0101; tick();
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd3; tick();
        chk("be_merge", rd_data_a, 32'hAA22CC44);
        idle(); tick(); tick();

        // Same-address read-during-write: OLD on dut_a, merged NEW on dut_b.
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h12345678; wr_be = 4'hF; tick();
        wr_data = 32'hDEADBEEF; wr_be = 4'b0011; rd_en = 1'b1; rd_addr = 4'd5; tick();
        chk("rdw_old", rd_data_a, 32'h12345678);
        wr_en = 1'b0; tick();
        chk("rdw_new", rd_data_b, 32'h1234BEEF);
        chk("rdw_after", rd_data_a, 32'h1234BEEF);
        idle(); tick(); tick();

        // Back-to-back burst through the two-stage pipeline.
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = 32'(i); wr_be = 4'hF; tick();
        end
        wr_en = 1'b0;
        for (int j = 0; j < 12; j++) begin
            rd_en = (j < 8); rd_addr = AW'(j);
            tick();
            chk("lat2_valid", 32'(rd_valid_b), 32'(j >= 1 && j <= 8));
            if (j >= 1 && j <= 8) chk("lat2_data", rd_data_b, 32'(j - 1));
        end
        idle();

        // Random traffic concentrated on a few addresses to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = AW'($urandom_range(0, 3));
            wr_data = $urandom;
            wr_be   = 4'($urandom_range(0, 15));
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = AW'($urandom_range(0, 3));
            tick();
        end
        idle(); tick(); tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
